uart_byte_adder: RTL and testbench
==================================

Name: uart_byte_adder

Overview:
- Sits between UartRx and UartTx in the loopback path; consumes received bytes and produces transmit messages.
- Captures two consecutive received bytes, forms their 9-bit sum, and hands it to UartTx as a 16-bit message.
- Performs the start/idle handshake with UartTx.
- Runs entirely on the system clock; UartTx's idle, which comes from the uartClk domain, is synchronised internally.

Parameters:
- DATA_WIDTH, 8: width of each received operand.
- MSG_WIDTH, 16: width of txMessage; must be at least DATA_WIDTH+1; sum is zero-extended into it.
- TIMEOUT_CYCLES, 20000: max clk cycles between first and second byte before the first is discarded; must be at least 2.
- SYNC_STAGES, 2: flop stages synchronising txIdle into the clk domain; must be at least 2.

Ports:
- clk  in  1  system clock, all state on posedge.
- rstN  in  1  asynchronous active-low reset.
- rxData  in  DATA_WIDTH  byte from UartRx; valid while dataIsValid is high.
- dataIsValid  in  1  UartRx valid level; may stay high for many cycles per byte.
- txMessage  out  MSG_WIDTH  message to UartTx; {zero pad, carry, sum}.
- txStart  out  1  start request to UartTx.
- txIdle  in  1  UartTx idle, uartClk domain; async to clk.
- busy  out  1  high in every state except WAIT_A.
- overrun  out  1  sticky; set when a byte arrives while it cannot be accepted.
- timeout  out  1  one-cycle pulse when a pending first byte is discarded.

Behaviour:
- Reset, asynchronous, while rstN is low:
  - State = WAIT_A; txMessage = 0; txStart = 0; busy = 0; overrun = 0; timeout = 0.
  - Operand register = 0; timeout counter = 0.
  - Edge-detect history flop = 1, so a dataIsValid already high at reset release is not counted.
  - Synchroniser flops = 1 (idle).
- Byte event:
  - A byte event is a cycle with dataIsValid high and the history flop low.
  - rxData is sampled in that same cycle.
  - A held-high dataIsValid yields exactly one event.
- WAIT_A:
  - On a byte event, store rxData in opA, clear the counter, go to WAIT_B.
- WAIT_B:
  - The counter increments each cycle.
  - On a byte event, register txMessage = zero-extended (opA + rxData) computed at DATA_WIDTH+1 bits, then go to SEND. txStart and the new txMessage are both visible on the next cycle (1-cycle latency from the second byte event).
  - Else, if the counter reaches TIMEOUT_CYCLES-1, discard opA, pulse timeout for 1 cycle, go to WAIT_A.
  - If a byte event and the timeout occur in the same cycle, the byte wins: the sum is formed and no timeout pulse is generated.
- SEND:
  - txStart = 1.
  - Stay until the synchronised txIdle is 0 (UartTx has accepted the message), then go to WAIT_DONE.
  - No timeout applies in SEND; the wait can be indefinite.
- WAIT_DONE:
  - txStart = 0.
  - Stay until the synchronised txIdle is 1, then go to WAIT_A.
- txMessage is held stable from entry to SEND until the next sum is formed.
- Overrun and dropped bytes:
  - A byte event in SEND or WAIT_DONE sets overrun; the byte is dropped.
  - overrun is cleared only by reset.
- Arithmetic:
  - Unsigned addition; the carry lands in bit DATA_WIDTH; no saturation.
  - Example: 0xFF + 0xFF = 0x1FE gives txMessage 0x01FE.
- Reset mid-operation: reset asserted in any state returns all outputs to their reset values immediately (asynchronous).
  - A transmission already accepted by UartTx is not aborted; UartTx owns it.
  - After reset release, the block waits in WAIT_A. It does not re-trigger on the stale idle state.

Test Plan:
- Bytes 0x11 then 0x22, each with dataIsValid held for 100 cycles -> txMessage=0x0033; txStart rises 1 cycle after the second event; txStart falls after txIdle goes low; busy falls after txIdle returns high.
- Bytes 0xFF then 0x01 -> txMessage=0x0100; bytes 0xFF then 0xFF -> txMessage=0x01FE.
- Byte 0x44, then nothing for TIMEOUT_CYCLES -> single-cycle timeout pulse, state WAIT_A, txStart never asserted; then 0x01, 0x02 -> txMessage=0x0003.
- Bytes 0x10, 0x20, then a third byte 0x30 while txIdle is low -> overrun=1 and stays 1; txMessage remains 0x0030; the next pair 0x01, 0x01 after idle -> 0x0002.
- dataIsValid already high when rstN deasserts -> no byte counted; the following pulse counts as the first byte.
- rstN pulsed low while in WAIT_B with opA=0x55 -> all outputs 0 immediately; the next two bytes 0x01, 0x01 -> txMessage=0x0002, with no contribution from 0x55.

Source files
------------

// File: rtl/uart_byte_adder.sv
// Adds two consecutive UartRx bytes and hands the carry-extended sum to UartTx via a start/idle handshake.
// Sum and txStart appear 1 cycle after the second byte; bytes that arrive mid-transmit are dropped and flag overrun.
module uart_byte_adder #(
   parameter int DATA_WIDTH     = 8,
   parameter int MSG_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [DATA_WIDTH-1:0] rxData,
   input  logic                  dataIsValid,
   output logic [MSG_WIDTH-1:0]  txMessage,
   output logic                  txStart,
   input  logic                  txIdle,
   output logic                  busy,
   output logic                  overrun,
   output logic                  timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      WAIT_A    = 2'd0,
      WAIT_B    = 2'd1,
      SEND      = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [MSG_WIDTH-1:0]   msg_q, msg_d;
   logic                   ovr_q, ovr_d;
   logic                   tmo_q, tmo_d;
   logic                   hist_q, hist_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   logic                   byte_evt;
   logic                   idle_s;
   logic                   cnt_done;
   logic [DATA_WIDTH:0]    sum;

   assign byte_evt = dataIsValid & ~hist_q;
   assign idle_s   = sync_q[SYNC_STAGES-1];
   assign cnt_done = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign sum      = {1'b0, op_a_q} + {1'b0, rxData};

   // History and synchroniser reset high so a level already present at release is not an event.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= WAIT_A;
         op_a_q  <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         hist_q  <= 1'b1;
         sync_q  <= '1;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         hist_q  <= hist_d;
         sync_q  <= sync_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_A:    if (byte_evt) state_d = WAIT_B;
         WAIT_B: begin
            if (byte_evt)      state_d = SEND;
            else if (cnt_done) state_d = WAIT_A;
         end
         SEND:      if (!idle_s) state_d = WAIT_DONE;
         WAIT_DONE: if (idle_s)  state_d = WAIT_A;
         default:   state_d = WAIT_A;
      endcase
   end

   always_comb begin
      hist_d = dataIsValid;
      sync_d = {sync_q[SYNC_STAGES-2:0], txIdle};
      op_a_d = op_a_q;
      msg_d  = msg_q;
      cnt_d  = '0;
      tmo_d  = 1'b0;
      ovr_d  = ovr_q | (byte_evt && (state_q == SEND || state_q == WAIT_DONE));
      if (state_q == WAIT_A && byte_evt) begin
         op_a_d = rxData;
      end
      if (state_q == WAIT_B) begin
         // A byte landing on the final count still wins over the timeout.
         if (byte_evt) begin
            msg_d = MSG_WIDTH'(sum);
         end else if (cnt_done) begin
            op_a_d = '0;
            tmo_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      txStart   = (state_q == SEND);
      busy      = (state_q != WAIT_A);
      txMessage = msg_q;
      overrun   = ovr_q;
      timeout   = tmo_q;
   end

endmodule

// File: tb/tb_uart_byte_adder.sv
// Directed bench for uart_byte_adder: expected sums queued at stimulus, popped when txStart rises.
module tb_uart_byte_adder;

   localparam int DW = 8;
   localparam int MW = 16;
   localparam int T  = 200;

   logic          clk = 1'b0;
   logic          rstN;
   logic [DW-1:0] rxData;
   logic          dataIsValid;
   logic [MW-1:0] txMessage;
   logic          txStart;
   logic          txIdle;
   logic          busy;
   logic          overrun;
   logic          timeout;

   int n_checks = 0;
   int n_errors = 0;
   logic [MW-1:0] exp_q[$];

   uart_byte_adder #(
      .DATA_WIDTH(DW), .MSG_WIDTH(MW), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rstN(rstN), .rxData(rxData), .dataIsValid(dataIsValid),
      .txMessage(txMessage), .txStart(txStart), .txIdle(txIdle),
      .busy(busy), .overrun(overrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input int hold);
      @(negedge clk);
      rxData      = b;
      dataIsValid = 1'b1;
      repeat (hold) @(negedge clk);
      dataIsValid = 1'b0;
   endtask

   // First byte, short gap, then second byte with the 1-cycle latency checked.
   task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
      logic [MW-1:0] got;
      send_byte(a, hold);
      repeat (2) @(negedge clk);
      check("start_before_b", txStart, 0);
      exp_q.push_back(MW'({1'b0, a} + {1'b0, b}));
      rxData      = b;
      dataIsValid = 1'b1;
      @(negedge clk);
      check("start_latency", txStart, 1);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         got = exp_q.pop_front();
         check("msg", txMessage, got);
      end
      repeat (hold - 1) @(negedge clk);
      dataIsValid = 1'b0;
      check("busy_in_send", busy, 1);
   endtask

   task automatic accept();
      @(negedge clk);
      txIdle = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!txStart) break;
      end
      check("start_fall", txStart, 0);
      check("busy_after_accept", busy, 1);
   endtask

   task automatic finish_tx();
      @(negedge clk);
      txIdle = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("busy_fall", busy, 0);
   endtask

   task automatic handshake(input int low_len);
      accept();
      repeat (low_len) @(negedge clk);
      finish_tx();
   endtask

   initial begin
      int first_k;
      int pulses;
      logic start_seen;

      rstN        = 1'b0;
      rxData      = '0;
      dataIsValid = 1'b0;
      txIdle      = 1'b1;
      #23;
      check("rst_msg", txMessage, 0);
      check("rst_start", txStart, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      send_pair(8'h11, 8'h22, 100);
      handshake(10);
      send_pair(8'hFF, 8'h01, 5);
      handshake(4);
      send_pair(8'hFF, 8'hFF, 5);
      handshake(4);

      // Lone byte: timeout must pulse exactly T edges after the event edge.
      @(negedge clk);
      rxData      = 8'h44;
      dataIsValid = 1'b1;
      @(posedge clk);
      first_k    = 0;
      pulses     = 0;
      start_seen = 1'b0;
      for (int k = 1; k <= T + 4; k++) begin
         @(posedge clk);
         #1;
         dataIsValid = 1'b0;
         if (timeout) begin
            if (first_k == 0) first_k = k;
            pulses++;
         end
         if (txStart) start_seen = 1'b1;
      end
      check("timeout_edge", first_k, T);
      check("timeout_width", pulses, 1);
      check("timeout_no_start", start_seen, 0);
      check("timeout_idle", busy, 0);
      send_pair(8'h01, 8'h02, 3);
      handshake(4);

      send_pair(8'h10, 8'h20, 3);
      accept();
      send_byte(8'h30, 3);
      @(negedge clk);
      check("overrun_set", overrun, 1);
      check("overrun_msg_held", txMessage, 16'h0030);
      finish_tx();
      check("overrun_sticky", overrun, 1);
      send_pair(8'h01, 8'h01, 3);
      handshake(4);
      check("overrun_still", overrun, 1);

      // Valid already high at reset release must not count as a byte.
      @(negedge clk);
      rstN        = 1'b0;
      rxData      = 8'h77;
      dataIsValid = 1'b1;
      #1;
      check("rst_clears_overrun", overrun, 0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (5) @(negedge clk);
      check("stale_valid_ignored", busy, 0);
      dataIsValid = 1'b0;
      @(negedge clk);
      send_pair(8'h03, 8'h04, 3);
      handshake(4);

      // Reset while holding a first operand discards it.
      send_byte(8'h55, 2);
      @(negedge clk);
      check("wait_b_busy", busy, 1);
      rstN = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_start", txStart, 0);
      check("midrst_msg", txMessage, 0);
      check("midrst_timeout", timeout, 0);
      check("midrst_overrun", overrun, 0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      send_pair(8'h01, 8'h01, 3);
      handshake(4);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
